// File: rtl/prepaid_meter_core.sv
// prepaid_meter_core
// Synchronises meter pulses and bills each unit at its tier rate against a
// saturating prepaid balance. It drives the supply relay through an
// ACTIVE/LOW/CUTOFF state machine and tracks the daily cost.
// Optional feature macro: PREPAID_DAYS_EST_EN. When it is defined, a
// sequential restoring divider estimates days_left = balance / day_cost.
//
// state     | meaning
// ----------+-----------------------------------------------
// ST_ACTIVE | balance above DANGER_LVL, relay on, no alerts
// ST_LOW    | 0 < balance <= DANGER_LVL, relay on, alert1
// ST_CUTOFF | balance == 0, relay off, pulses ignored
module prepaid_meter_core #(
   parameter int UNIT_W      = 10,
   parameter int BAL_W       = 10,
   parameter int FREE_LIMIT  = 50,
   parameter int TIER1_LIMIT = 100,
   parameter int TIER2_LIMIT = 200,
   parameter int RATE1       = 1,
   parameter int RATE2       = 2,
   parameter int RATE3       = 3,
   parameter int DANGER_LVL  = 45,
   parameter int DAYS_MAX    = 31
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              sensor,
   input  logic              day_tick,
   input  logic              recharge_valid,
   input  logic [BAL_W-1:0]  recharge_amt,
   output logic              recharge_ready,
   output logic [BAL_W-1:0]  balance,
   output logic [UNIT_W-1:0] units_cons,
   output logic [4:0]        date,
   output logic [BAL_W-1:0]  day_cost,
   output logic [BAL_W-1:0]  days_left,
   output logic              relay_on,
   output logic              alert1,
   output logic              alert2
);

   localparam logic [1:0] ST_ACTIVE = 2'd0;
   localparam logic [1:0] ST_LOW    = 2'd1;
   localparam logic [1:0] ST_CUTOFF = 2'd2;

   localparam logic [BAL_W-1:0]  BAL_MAX  = {BAL_W{1'b1}};
   localparam logic [UNIT_W-1:0] UNIT_MAX = {UNIT_W{1'b1}};

   logic [1:0]        state;
   logic              s1, s2, s3;
   logic              pulse;
   logic              unit_ev;
   logic              wrap;
   logic              hs;
   logic [UNIT_W-1:0] base;
   logic [UNIT_W:0]   n_ext;
   logic [UNIT_W-1:0] units_nxt;
   logic [BAL_W-1:0]  charge;
   logic [BAL_W-1:0]  acc_amt;
   logic [BAL_W:0]    bal_sum;
   logic [BAL_W:0]    bal_diff;
   logic [BAL_W-1:0]  bal_nxt;
   logic [1:0]        state_nxt;
   logic [BAL_W-1:0]  day_acc;
   logic [BAL_W:0]    da_sum;
   logic [BAL_W-1:0]  day_acc_nxt;

   // Two-flop synchroniser plus a history flop for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
         s3 <= 1'b0;
      end else begin
         s1 <= sensor;
         s2 <= s1;
         s3 <= s2;
      end
   end

   assign pulse = s2 & ~s3;
   assign hs    = recharge_valid & recharge_ready;

   // Tier lookup for the next unit. A unit that arrives on the wrap tick is
   // billed as the first unit of the new period.
   always_comb begin
      wrap      = day_tick && (date == 5'(DAYS_MAX));
      base      = wrap ? '0 : units_cons;
      unit_ev   = pulse && (state != ST_CUTOFF);
      n_ext     = {1'b0, base} + {{UNIT_W{1'b0}}, 1'b1};
      units_nxt = (base == UNIT_MAX) ? UNIT_MAX : n_ext[UNIT_W-1:0];
      charge    = '0;
      if (unit_ev) begin
         if (base == UNIT_MAX)
            charge = BAL_W'(RATE3);
         else if (int'(n_ext) <= FREE_LIMIT)
            charge = '0;
         else if (int'(n_ext) <= TIER1_LIMIT)
            charge = BAL_W'(RATE1);
         else if (int'(n_ext) <= TIER2_LIMIT)
            charge = BAL_W'(RATE2);
         else
            charge = BAL_W'(RATE3);
      end
   end

   // Saturating balance and daily-accumulator arithmetic, plus the next-state decode
   always_comb begin
      acc_amt  = hs ? recharge_amt : '0;
      bal_sum  = {1'b0, balance} + {1'b0, acc_amt};
      bal_diff = bal_sum - {1'b0, charge};
      if (bal_sum < {1'b0, charge})
         bal_nxt = '0;
      else if (bal_diff[BAL_W])
         bal_nxt = BAL_MAX;
      else
         bal_nxt = bal_diff[BAL_W-1:0];

      da_sum      = {1'b0, day_acc} + {1'b0, charge};
      day_acc_nxt = da_sum[BAL_W] ? BAL_MAX : da_sum[BAL_W-1:0];

      if (bal_nxt == '0)
         state_nxt = ST_CUTOFF;
      else if (bal_nxt <= BAL_W'(DANGER_LVL))
         state_nxt = ST_LOW;
      else
         state_nxt = ST_ACTIVE;
   end

   // Billing registers: balance and state move together, and the day tick rolls the counters
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         balance    <= '0;
         state      <= ST_CUTOFF;
         units_cons <= '0;
         date       <= 5'd1;
         day_acc    <= '0;
         day_cost   <= '0;
      end else begin
         balance <= bal_nxt;
         state   <= state_nxt;
         if (unit_ev)
            units_cons <= units_nxt;
         else if (wrap)
            units_cons <= '0;
         if (day_tick) begin
            day_cost <= day_acc;
            day_acc  <= charge;
            date     <= wrap ? 5'd1 : date + 5'd1;
         end else begin
            day_acc  <= day_acc_nxt;
         end
      end
   end

   assign relay_on = (state != ST_CUTOFF);
   assign alert1   = (state != ST_ACTIVE);
   assign alert2   = (state == ST_CUTOFF);

`ifdef PREPAID_DAYS_EST_EN
   localparam int CNT_W = $clog2(BAL_W + 1);

   logic             busy;
   logic             pend;
   logic             tick_d;
   logic             start;
   logic [CNT_W-1:0] cnt;
   logic [BAL_W:0]   rem;
   logic [BAL_W:0]   rem_sh;
   logic [BAL_W:0]   rem_nx;
   logic [BAL_W-1:0] quo;
   logic [BAL_W-1:0] quo_nx;
   logic [BAL_W-1:0] dvs;
   logic [BAL_W-1:0] days_q;
   logic             ge;

   // One restoring step: shift in the next dividend bit and subtract if it fits.
   // A zero divisor always fits, so the quotient comes out all ones.
   always_comb begin
      rem_sh = {rem[BAL_W-1:0], quo[BAL_W-1]};
      ge     = (rem_sh >= {1'b0, dvs});
      rem_nx = ge ? rem_sh - {1'b0, dvs} : rem_sh;
      quo_nx = {quo[BAL_W-2:0], ge};
      start  = !busy && (tick_d || pend);
   end

   // Divider sequencing, with room for one queued restart while busy
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         busy   <= 1'b0;
         pend   <= 1'b0;
         tick_d <= 1'b0;
         cnt    <= '0;
         rem    <= '0;
         quo    <= '0;
         dvs    <= '0;
         days_q <= '0;
      end else begin
         tick_d <= day_tick;
         if (start) begin
            busy <= 1'b1;
            pend <= 1'b0;
            cnt  <= CNT_W'(BAL_W);
            rem  <= '0;
            quo  <= balance;
            dvs  <= day_cost;
         end else if (busy) begin
            rem <= rem_nx;
            quo <= quo_nx;
            cnt <= cnt - CNT_W'(1);
            if (cnt == CNT_W'(1)) begin
               busy   <= 1'b0;
               days_q <= quo_nx;
            end
            if (tick_d)
               pend <= 1'b1;
         end
      end
   end

   assign recharge_ready = ~busy;
   assign days_left      = days_q;
`else
   assign recharge_ready = 1'b1;
   assign days_left      = '0;
`endif

endmodule

// File: tb/tb_prepaid_meter_core.sv
// Directed bench for prepaid_meter_core. Expected values are queued before
// each stimulus step and compared against the DUT afterwards.
module tb_prepaid_meter_core;

   logic       clk = 1'b0;
   logic       reset;
   logic       sensor;
   logic       day_tick;
   logic       recharge_valid;
   logic [9:0] recharge_amt;
   logic       recharge_ready;
   logic [9:0] balance;
   logic [9:0] units_cons;
   logic [4:0] date;
   logic [9:0] day_cost;
   logic [9:0] days_left;
   logic       relay_on;
   logic       alert1;
   logic       alert2;

   prepaid_meter_core dut (
      .clk            (clk),
      .reset          (reset),
      .sensor         (sensor),
      .day_tick       (day_tick),
      .recharge_valid (recharge_valid),
      .recharge_amt   (recharge_amt),
      .recharge_ready (recharge_ready),
      .balance        (balance),
      .units_cons     (units_cons),
      .date           (date),
      .day_cost       (day_cost),
      .days_left      (days_left),
      .relay_on       (relay_on),
      .alert1         (alert1),
      .alert2         (alert2)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   checks = 0;
   int   errors = 0;

`ifdef PREPAID_DAYS_EST_EN
   localparam int EXP_BUSY = 10;
   localparam int EXP_DAYS = 4;
`else
   localparam int EXP_BUSY = 0;
   localparam int EXP_DAYS = 0;
`endif

   task automatic sb_push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic sb_check(input logic [31:0] obs);
      exp_t e;
      checks++;
      if (sb_q.size() == 0) begin
         errors++;
         $error("FAIL sb_underflow: observed %0d with no expected value", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", e.tag, obs, e.val);
         end
      end
   endtask

   // st: 0 ACTIVE, 1 LOW, 2 CUTOFF
   task automatic exp_main(input int bal, input int un, input int st);
      sb_push("balance", bal);
      sb_push("units_cons", un);
      sb_push("relay_on", (st != 2) ? 1 : 0);
      sb_push("alert1", (st != 0) ? 1 : 0);
      sb_push("alert2", (st == 2) ? 1 : 0);
   endtask

   task automatic obs_main();
      sb_check(balance);
      sb_check(units_cons);
      sb_check(relay_on);
      sb_check(alert1);
      sb_check(alert2);
   endtask

   task automatic exp_reset();
      exp_main(0, 0, 2);
      sb_push("date", 1);
      sb_push("day_cost", 0);
      sb_push("days_left", 0);
      sb_push("recharge_ready", 1);
   endtask

   task automatic obs_all();
      obs_main();
      sb_check(date);
      sb_check(day_cost);
      sb_check(days_left);
      sb_check(recharge_ready);
   endtask

   task automatic pulse();
      sensor = 1'b1;
      repeat (2) @(negedge clk);
      sensor = 1'b0;
      repeat (2) @(negedge clk);
   endtask

   task automatic pulses(input int n);
      for (int i = 0; i < n; i++) pulse();
   endtask

   task automatic recharge(input int amt);
      int w;
      w = 0;
      recharge_valid = 1'b1;
      recharge_amt   = 10'(amt);
      while (!recharge_ready && w < 50) begin
         @(negedge clk);
         w++;
      end
      if (!recharge_ready) begin
         checks++;
         errors++;
         $error("FAIL recharge_timeout: observed ready %0d expected 1", recharge_ready);
      end
      @(negedge clk);
      recharge_valid = 1'b0;
   endtask

   task automatic tick();
      day_tick = 1'b1;
      @(negedge clk);
      day_tick = 1'b0;
   endtask

   initial begin
      int busy_cnt;
      reset          = 1'b0;
      sensor         = 1'b0;
      day_tick       = 1'b0;
      recharge_valid = 1'b0;
      recharge_amt   = '0;
      repeat (3) @(negedge clk);
      exp_reset();
      obs_all();
      reset = 1'b1;
      @(negedge clk);

      // pulses are ignored while in CUTOFF
      exp_main(0, 0, 2);
      pulse();
      obs_main();

      exp_main(100, 0, 0);
      recharge(100);
      obs_main();

      exp_main(90, 60, 0);
      pulses(60);
      obs_main();

      exp_main(40, 105, 1);
      pulses(45);
      obs_main();

      exp_main(5, 125, 1);
      recharge(5);
      pulses(20);
      obs_main();

      // recharge 10 is accepted on the same edge that bills RATE2 unit 126
      exp_main(13, 126, 1);
      sensor = 1'b1;
      repeat (2) @(negedge clk);
      sensor         = 1'b0;
      recharge_valid = 1'b1;
      recharge_amt   = 10'd10;
      @(negedge clk);
      recharge_valid = 1'b0;
      repeat (2) @(negedge clk);
      obs_main();

      exp_main(2, 200, 1);
      recharge(137);
      pulses(74);
      obs_main();

      exp_main(0, 201, 2);
      pulse();
      obs_main();

      exp_main(0, 201, 2);
      pulses(3);
      obs_main();

      exp_main(50, 201, 0);
      recharge(50);
      obs_main();

      // Accumulated cost: 10 + 50 + 40 + 2 + 148 + 3
      sb_push("day_cost_first", 253);
      sb_push("date_first", 2);
      tick();
      repeat (14) @(negedge clk);
      sb_check(day_cost);
      sb_check(date);

      sb_push("date_last", 31);
      sb_push("day_cost_idle", 0);
      sb_push("units_before_wrap", 201);
      for (int i = 0; i < 29; i++) begin
         tick();
         repeat (14) @(negedge clk);
      end
      sb_check(date);
      sb_check(day_cost);
      sb_check(units_cons);

      sb_push("date_wrap", 1);
      sb_push("units_wrap", 0);
      sb_push("balance_wrap", 50);
      tick();
      repeat (14) @(negedge clk);
      sb_check(date);
      sb_check(units_cons);
      sb_check(balance);

      exp_main(90, 70, 0);
      recharge(60);
      pulses(70);
      obs_main();

      sb_push("day_cost_20", 20);
      sb_push("busy_cycles", EXP_BUSY);
      sb_push("days_left", EXP_DAYS);
      sb_push("ready_after", 1);
      tick();
      @(negedge clk);
      busy_cnt = 0;
      for (int i = 0; i < 10; i++) begin
         if (!recharge_ready) busy_cnt++;
         @(negedge clk);
      end
      sb_check(day_cost);
      sb_check(busy_cnt);
      sb_check(days_left);
      sb_check(recharge_ready);

      exp_main(100, 70, 0);
      recharge(10);
      obs_main();

      exp_main(1023, 70, 0);
      recharge(1000);
      obs_main();

      // reset while the divider is running
      tick();
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      exp_reset();
      obs_all();
      reset = 1'b1;
      sb_push("days_left_post", 0);
      sb_push("ready_post", 1);
      repeat (20) @(negedge clk);
      sb_check(days_left);
      sb_check(recharge_ready);

      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $error("FAIL sb_leftover: observed %0d entries expected 0", sb_q.size());
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
